// File: rtl/fib_axis_pkg.sv
// Shared constants and types for the FIB AXI-Stream bridges.
package fib_axis_pkg;

   localparam int unsigned DATA_WIDTH     = 256;
   localparam int unsigned BCNT_WIDTH     = 64;
   localparam int unsigned BYTES_PER_WORD = 32;
   localparam int unsigned BYTE_CNT_W     = 16;

   // One-hot TX ingress states
   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_DATA = 3'b010,
      ST_CNT  = 3'b100
   } state_e;

   // Number of FIFO words needed to hold a packet of max_bytes bytes
   function automatic int unsigned max_words(input int unsigned max_bytes);
      return (max_bytes + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
   endfunction

endpackage

// File: rtl/fib_keep_popcnt.sv
// Combinational byte-enable population count (tkeep -> number of valid bytes).
module fib_keep_popcnt #(
   parameter  int unsigned KEEP_W = 32,
   localparam int unsigned CNT_W  = $clog2(KEEP_W + 1)
) (
   input  logic [KEEP_W-1:0] keep_i,
   output logic [CNT_W-1:0]  cnt_o
);

   // Sum every enable bit
   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < KEEP_W; i++) begin
         cnt_o = cnt_o + CNT_W'(keep_i[i]);
      end
   end

endmodule

// File: rtl/axis2fib_txwr.sv
// TX ingress: AXI-Stream packets into the data FIFO (wf) plus one byte-count
// entry per packet into the count FIFO (wcf), written only after the packet.
module axis2fib_txwr
   import fib_axis_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 256,
   parameter int unsigned BCNT_WIDTH    = 64,
   parameter int unsigned WF_AW         = 10,
   parameter int unsigned MAX_PKT_BYTES = 9600
) (
   input  logic                    clk_fib,
   input  logic                    reset_,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   input  logic [WF_AW-1:0]        wrusedw_wf,
   input  logic                    wrfull_wcf,
   output logic                    wrreq_wf,
   output logic [DATA_WIDTH-1:0]   datain_wf,
   output logic                    wrreq_wcf,
   output logic [BCNT_WIDTH-1:0]   datain_wcf,
   output logic [31:0]             pkt_cnt,
   output logic                    err_trunc,
   output logic                    err_tkeep
);

   localparam int unsigned KEEP_W    = DATA_WIDTH / 8;
   localparam int unsigned PCNT_W    = $clog2(KEEP_W + 1);
   localparam int unsigned MAX_WORDS = max_words(MAX_PKT_BYTES);
   // Start a packet only if a maximum-size packet still fits, with slack for
   // the write pipeline.
   localparam int unsigned ROOM_THR  = (1 << WF_AW) - MAX_WORDS - 4;

   state_e                  state_q, state_d;
   logic                    run_q;
   logic                    room, beat_acc, beat_wr;
   logic [PCNT_W-1:0]       keep_cnt;
   logic [BYTE_CNT_W-1:0]   bytes_q, bytes_d;
   logic [15:0]             words_q, words_d;
   logic                    trunc_q, trunc_d;
   logic                    wrreq_wf_q, wrreq_wcf_q, err_trunc_q, err_tkeep_q;
   logic [DATA_WIDTH-1:0]   datain_wf_q;
   logic [BCNT_WIDTH-1:0]   datain_wcf_q;
   logic [31:0]             pkt_cnt_q;

   fib_keep_popcnt #(
      .KEEP_W (KEEP_W)
   ) u_popcnt (
      .keep_i (s_axis_tkeep),
      .cnt_o  (keep_cnt)
   );

   assign room     = (32'(wrusedw_wf) <= ROOM_THR) && !wrfull_wcf;
   assign beat_acc = s_axis_tvalid && s_axis_tready;
   // Beats past MAX_WORDS are still accepted but dropped
   assign beat_wr  = beat_acc && (words_q < 16'(MAX_WORDS));

   // State register
   always_ff @(posedge clk_fib or negedge reset_) begin
      if (!reset_) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (beat_acc) state_d = s_axis_tlast ? ST_CNT : ST_DATA;
         ST_DATA: if (beat_acc && s_axis_tlast) state_d = ST_CNT;
         ST_CNT:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs; run_q keeps tready low until the first edge after reset release
   always_comb begin
      s_axis_tready = 1'b0;
      unique case (state_q)
         ST_IDLE: s_axis_tready = room && run_q;
         ST_DATA: s_axis_tready = 1'b1;
         ST_CNT:  s_axis_tready = 1'b0;
         default: s_axis_tready = 1'b0;
      endcase
   end

   // Per-packet byte/word accumulation, cleared on the way back to IDLE
   always_comb begin
      bytes_d = bytes_q;
      words_d = words_q;
      trunc_d = trunc_q;
      if (state_q == ST_CNT) begin
         bytes_d = '0;
         words_d = '0;
         trunc_d = 1'b0;
      end else if (beat_wr) begin
         bytes_d = bytes_q + BYTE_CNT_W'(keep_cnt);
         words_d = words_q + 16'd1;
      end else if (beat_acc) begin
         trunc_d = 1'b1;
      end
   end

   // Counters and registered FIFO-side outputs
   always_ff @(posedge clk_fib or negedge reset_) begin
      if (!reset_) begin
         run_q        <= 1'b0;
         bytes_q      <= '0;
         words_q      <= '0;
         trunc_q      <= 1'b0;
         wrreq_wf_q   <= 1'b0;
         datain_wf_q  <= '0;
         wrreq_wcf_q  <= 1'b0;
         datain_wcf_q <= '0;
         pkt_cnt_q    <= '0;
         err_trunc_q  <= 1'b0;
         err_tkeep_q  <= 1'b0;
      end else begin
         run_q       <= 1'b1;
         bytes_q     <= bytes_d;
         words_q     <= words_d;
         trunc_q     <= trunc_d;
         wrreq_wf_q  <= beat_wr;
         if (beat_wr) datain_wf_q <= s_axis_tdata;
         wrreq_wcf_q <= (state_q == ST_CNT);
         if (state_q == ST_CNT) begin
            datain_wcf_q <= BCNT_WIDTH'(bytes_q);
            pkt_cnt_q    <= pkt_cnt_q + 32'd1;
         end
         err_trunc_q <= (state_q == ST_CNT) && trunc_q;
         err_tkeep_q <= beat_acc && !s_axis_tlast && (s_axis_tkeep != '1);
      end
   end

   assign wrreq_wf   = wrreq_wf_q;
   assign datain_wf  = datain_wf_q;
   assign wrreq_wcf  = wrreq_wcf_q;
   assign datain_wcf = datain_wcf_q;
   assign pkt_cnt    = pkt_cnt_q;
   assign err_trunc  = err_trunc_q;
   assign err_tkeep  = err_tkeep_q;

endmodule

// File: tb/tb_axis2fib_txwr.sv
// Directed bench for axis2fib_txwr with a scoreboard for wf and wcf writes.
module tb_axis2fib_txwr;

   localparam int unsigned MAX_WORDS = 300;  // ceil(9600 / 32)

   logic         clk_fib = 1'b0;
   logic         reset_;
   logic [255:0] s_axis_tdata;
   logic [31:0]  s_axis_tkeep;
   logic         s_axis_tvalid;
   logic         s_axis_tlast;
   logic         s_axis_tready;
   logic [9:0]   wrusedw_wf;
   logic         wrfull_wcf;
   logic         wrreq_wf;
   logic [255:0] datain_wf;
   logic         wrreq_wcf;
   logic [63:0]  datain_wcf;
   logic [31:0]  pkt_cnt;
   logic         err_trunc;
   logic         err_tkeep;

   int total = 0;
   int bad   = 0;
   int waits = 0;
   int cyc   = 0;
   int last_wf_cyc = -10;

   // Scoreboard and reference model
   logic [255:0] wf_q[$];
   logic [63:0]  cnt_q[$];
   logic         tr_q[$];
   int           m_words = 0;
   int           m_bytes = 0;
   logic         m_trunc = 1'b0;
   logic [31:0]  exp_pkt = 0;

   axis2fib_txwr #(
      .DATA_WIDTH    (256),
      .BCNT_WIDTH    (64),
      .WF_AW         (10),
      .MAX_PKT_BYTES (9600)
   ) dut (
      .clk_fib       (clk_fib),
      .reset_        (reset_),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .wrusedw_wf    (wrusedw_wf),
      .wrfull_wcf    (wrfull_wcf),
      .wrreq_wf      (wrreq_wf),
      .datain_wf     (datain_wf),
      .wrreq_wcf     (wrreq_wcf),
      .datain_wcf    (datain_wcf),
      .pkt_cnt       (pkt_cnt),
      .err_trunc     (err_trunc),
      .err_tkeep     (err_tkeep)
   );

   always #5 clk_fib = ~clk_fib;

   always @(posedge clk_fib) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Drive one beat and hold it until accepted; update the model on acceptance
   task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk_fib);
         acc = s_axis_tready;
         @(posedge clk_fib);
         #1;
         if (!acc) n++;
      end
      waits = n;
      chk("beat_accepted", acc, 1'b1);
      if (acc) begin
         if (m_words < MAX_WORDS) begin
            wf_q.push_back(d);
            m_words++;
            m_bytes += $countones(k);
         end else begin
            m_trunc = 1'b1;
         end
         if (l) begin
            cnt_q.push_back(64'(m_bytes));
            tr_q.push_back(m_trunc);
            m_words = 0;
            m_bytes = 0;
            m_trunc = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (n) @(posedge clk_fib);
      #1;
   endtask

   // Output monitor: pop expectations whenever a FIFO write appears
   always @(negedge clk_fib) begin
      if (reset_) begin
         if (wrreq_wf) begin
            last_wf_cyc = cyc;
            chk("wf_expected", logic'(wf_q.size() != 0), 1'b1);
            if (wf_q.size() != 0) chk("wf_data", datain_wf, wf_q.pop_front());
         end
         if (wrreq_wcf) begin
            chk("wcf_expected", logic'(cnt_q.size() != 0), 1'b1);
            if (cnt_q.size() != 0) begin
               logic tr;
               tr = tr_q.pop_front();
               exp_pkt = exp_pkt + 1;
               chk("wcf_count", datain_wcf, cnt_q.pop_front());
               chk("err_trunc", err_trunc, tr);
               chk("pkt_cnt", pkt_cnt, exp_pkt);
               if (!tr) chk("wcf_after_last_wf", 32'(last_wf_cyc), 32'(cyc - 1));
            end
         end else begin
            chk("err_trunc_idle", err_trunc, 1'b0);
         end
      end
   end

   initial begin
      logic [255:0] d;
      reset_        = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      wrusedw_wf    = '0;
      wrfull_wcf    = 1'b0;

      // Reset state
      #2;
      chk("rst_tready", s_axis_tready, 1'b0);
      chk("rst_wrreq_wf", wrreq_wf, 1'b0);
      chk("rst_wrreq_wcf", wrreq_wcf, 1'b0);
      chk("rst_datain_wcf", datain_wcf, 64'd0);
      chk("rst_pkt_cnt", pkt_cnt, 32'd0);
      chk("rst_errs", {err_trunc, err_tkeep}, 2'b00);
      #10 reset_ = 1'b1;
      idle(2);

      // 100-byte packet: 3 full beats and a 4-byte tail
      for (int i = 0; i < 4; i++) send_beat(rnd256(), (i == 3) ? 32'h0000_000F : '1, i == 3);
      idle(4);
      chk("pkt100_pkt_cnt", pkt_cnt, 32'd1);

      // Two back-to-back 64-byte packets; only the CNT bubble may stall
      begin
         int sum;
         sum = 0;
         send_beat(rnd256(), '1, 1'b0); sum += waits;
         send_beat(rnd256(), '1, 1'b1); sum += waits;
         send_beat(rnd256(), '1, 1'b0);
         chk("b2b_cnt_bubble", 32'(waits), 32'd1);
         send_beat(rnd256(), '1, 1'b1); sum += waits;
         chk("b2b_no_other_stall", 32'(sum), 32'd0);
      end
      idle(4);

      // No room in wf: hold off, then start once room appears and never stall
      d = rnd256();
      s_axis_tdata  = d;
      s_axis_tkeep  = '1;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      wrusedw_wf    = 10'd800;
      repeat (3) begin
         @(negedge clk_fib);
         chk("noroom_tready", s_axis_tready, 1'b0);
         chk("noroom_wrreq", wrreq_wf, 1'b0);
      end
      @(posedge clk_fib);
      #1 wrusedw_wf = 10'd700;
      send_beat(d, '1, 1'b0);
      chk("room_start", 32'(waits), 32'd0);
      wrusedw_wf = 10'd800;
      send_beat(rnd256(), '1, 1'b0);
      chk("room_hold1", 32'(waits), 32'd0);
      send_beat(rnd256(), 32'h0000_00FF, 1'b1);
      chk("room_hold2", 32'(waits), 32'd0);
      idle(3);
      wrusedw_wf = '0;

      // Count FIFO full blocks admission; then a zero-byte packet
      wrfull_wcf    = 1'b1;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b1;
      s_axis_tvalid = 1'b1;
      repeat (2) begin
         @(negedge clk_fib);
         chk("wcf_full_tready", s_axis_tready, 1'b0);
      end
      @(posedge clk_fib);
      #1 wrfull_wcf = 1'b0;
      send_beat(rnd256(), '0, 1'b1);
      idle(4);

      // Partial tkeep on a non-last beat
      send_beat(rnd256(), 32'h7FFF_FFFF, 1'b0);
      chk("err_tkeep_pulse", err_tkeep, 1'b1);
      send_beat(rnd256(), '1, 1'b0);
      chk("err_tkeep_clear", err_tkeep, 1'b0);
      send_beat(rnd256(), 32'h0000_0003, 1'b1);
      chk("err_tkeep_last", err_tkeep, 1'b0);
      idle(4);

      // Oversize packet: 302 beats, only MAX_WORDS written, count saturates
      for (int i = 0; i < 302; i++) send_beat(rnd256(), '1, i == 301);
      idle(4);
      chk("trunc_wf_drained", 32'(wf_q.size()), 32'd0);

      // Reset in the middle of a packet
      send_beat(rnd256(), '1, 1'b0);
      s_axis_tdata = rnd256();
      #1 reset_ = 1'b0;
      #1;
      chk("midrst_wrreq_wf", wrreq_wf, 1'b0);
      chk("midrst_tready", s_axis_tready, 1'b0);
      chk("midrst_pkt_cnt", pkt_cnt, 32'd0);
      chk("midrst_datain_wf", datain_wf, 256'd0);
      wf_q.delete();
      cnt_q.delete();
      tr_q.delete();
      m_words = 0;
      m_bytes = 0;
      m_trunc = 1'b0;
      exp_pkt = 0;
      s_axis_tvalid = 1'b0;
      repeat (2) @(posedge clk_fib);
      #2 reset_ = 1'b1;
      idle(2);
      send_beat(rnd256(), '1, 1'b0);
      send_beat(rnd256(), '1, 1'b0);
      send_beat(rnd256(), 32'h0000_03FF, 1'b1);
      idle(5);
      chk("post_rst_pkt_cnt", pkt_cnt, 32'd1);
      chk("post_rst_count", datain_wcf, 64'd74);

      chk("final_wf_drained", 32'(wf_q.size()), 32'd0);
      chk("final_wcf_drained", 32'(cnt_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis2fib_txwr.md
Name: axis2fib_txwr

Overview:
- TX ingress stage between the host AXI-Stream master and the dual-clock write FIFOs.
- Accepts 256-bit AXI-Stream packets and writes every data beat into the data FIFO (wf).
- After the last data beat of a packet, writes one 64-bit byte-count entry into the count FIFO (wcf).
- The FMAC-side TX controller reads both FIFOs and relies on this ordering: a count entry exists only once its whole packet is in wf.

Parameters:
- DATA_WIDTH, 256, data and tdata width (32 bytes per beat).
- BCNT_WIDTH, 64, count FIFO entry width.
- WF_AW, 10, address width of wf; depth = 2**WF_AW.
- MAX_PKT_BYTES, 9600, largest packet forwarded; longer packets are truncated.

Ports:
- clk_fib  in  1  single clock.
- reset_  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  256  packet data, byte 0 in [7:0].
- s_axis_tkeep  in  32  byte enables, contiguous from bit 0.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tready  out  1  beat accepted when tvalid & tready.
- wrusedw_wf  in  WF_AW  wf write-side used words.
- wrfull_wcf  in  1  wcf full.
- wrreq_wf  out  1  wf write enable.
- datain_wf  out  256  wf write data.
- wrreq_wcf  out  1  wcf write enable.
- datain_wcf  out  64  byte count in [15:0]; [63:16] = 0.
- pkt_cnt  out  32  packets committed to wcf, wraps.
- err_trunc  out  1  one-cycle pulse when a truncated packet is committed.
- err_tkeep  out  1  one-cycle pulse on a non-last beat whose tkeep != all-ones.

Behaviour:
- Reset (async assert, sync release) sets all outputs to 0, s_axis_tready = 0, state = IDLE, byte and word counters = 0.
- MAX_WORDS = ceil(MAX_PKT_BYTES/32) = 300. ROOM = (wrusedw_wf <= 2**WF_AW - MAX_WORDS - 4) & !wrfull_wcf.
- Packet admission:
  - A packet starts only when ROOM is true.
  - After start, tready stays high until tlast is accepted, so a packet never stalls mid-stream.
  - Admission guarantees the full packet fits in wf.
- State machine, one-hot:
  - IDLE: tready = ROOM. If a beat is accepted: go to CNT if tlast, otherwise DATA.
  - DATA: tready = 1. Accepted beat with tlast goes to CNT.
  - CNT: tready = 0 for exactly 1 cycle. Count entry is written. Next state is IDLE.
- Data write: a beat accepted in cycle N gives wrreq_wf = 1 and datain_wf = tdata in cycle N+1 (registered, 1-cycle latency). Bytes above tkeep are passed unmodified.
- Byte counting:
  - Each beat adds popcount(tkeep), 0..32.
  - Accumulator is 16 bits, cleared on entry to IDLE.
- Truncation:
  - Once MAX_WORDS words of a packet have been written, later beats are accepted (tready = 1) but not written and not counted.
  - The committed count saturates at MAX_WORDS*32.
  - A trunc flag is set and produces the err_trunc pulse at commit.
- Count write: in the cycle after the last data word is written (state CNT), wrreq_wcf = 1 and datain_wcf = {48'b0, bytes}.
- Commit pulses: pkt_cnt increments in that same cycle; err_trunc pulses with it if trunc is set.
- Zero-byte packet (single beat, tkeep = 0, tlast): one wf word is written and count 0 is committed. The downstream controller is responsible for discarding it.
- err_tkeep pulses 1 cycle after the offending beat. Counting still uses the popcount.
- Sustained throughput is one beat per cycle plus one bubble (CNT) per packet.
- tvalid low in DATA: state is held with no writes; it is not an error.
- Reset mid-packet: the partial data already in wf is not retracted. The owner of reset_ resets the FIFOs on the same edge.

Decomposition:
- Package fib_axis_pkg holds:
  - DATA_WIDTH, BCNT_WIDTH, BYTES_PER_WORD = 32;
  - one-hot state constants ST_IDLE = 3'b001, ST_DATA = 3'b010, ST_CNT = 3'b100;
  - MAX_WORDS computation.
- One sub-module, fib_keep_popcnt: combinational 32-bit tkeep to 6-bit count, reused by the RX bridge.

Test Plan:
- 100-byte packet, 4 beats, last tkeep = 32'h0000000F: 4 consecutive wrreq_wf; wrreq_wcf one cycle after the 4th with datain_wcf = 64'd100; pkt_cnt = 1.
- Two back-to-back 64-byte packets, tvalid held high: wf writes in cycles 1,2 and 4,5; wcf writes in cycles 3 and 6 with value 64; tready low only in the two CNT cycles.
- wrusedw_wf = 800 (> 1024-300-4 = 720) in IDLE: tready = 0 and no writes. Drop wrusedw_wf to 700: packet starts next cycle and completes even if wrusedw_wf rises again.
- MAX_PKT_BYTES = 96, 5-beat 160-byte packet: 3 wf writes; all 5 beats accepted; datain_wcf = 96; err_trunc pulse with wrreq_wcf.
- Non-last beat with tkeep = 32'h7FFFFFFF: err_tkeep pulse; count includes 31 for that beat.
- reset_ asserted during beat 2 of a 4-beat packet: outputs are 0 asynchronously; after release, state is IDLE and the next packet's count is correct (not accumulated).
